// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Byte-wide CPU memory responder that decodes each request into an
//            internal BIOS ROM, an external 16-bit asynchronous SRAM, or open
//            bus. SRAM accesses take SRAM_WAIT extra wait cycles.
// Options  : MEM_RESPONDER_READ_BUFFER_EN adds a one-word SRAM read buffer.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int unsigned SRAM_WAIT = 1,
    parameter logic [19:0] BIOS_BASE = 20'hF0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [19:0] cpu_address,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic [15:0] bios_addr,
    input  logic [7:0]  bios_data,
    output logic [17:0] sram_addr,
    input  logic [15:0] sram_dq_in,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BIOS    = 3'd1,
        SRAM_RD = 3'd2,
        SRAM_WR = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      r_state_q,       w_state_d;
    logic [2:0]  r_wait_q,        w_wait_d;
    logic        r_cpu_ready_q,   w_cpu_ready_d;
    logic [7:0]  r_cpu_rdata_q,   w_cpu_rdata_d;
    logic [15:0] r_bios_addr_q,   w_bios_addr_d;
    logic [17:0] r_sram_addr_q,   w_sram_addr_d;
    logic [15:0] r_sram_dq_out_q, w_sram_dq_out_d;
    logic        r_sram_dq_oe_q,  w_sram_dq_oe_d;
    logic        r_sram_we_n_q,   w_sram_we_n_d;
    logic        r_sram_oe_n_q,   w_sram_oe_n_d;
    logic        r_sram_ub_n_q,   w_sram_ub_n_d;
    logic        r_sram_lb_n_q,   w_sram_lb_n_d;

`ifdef MEM_RESPONDER_READ_BUFFER_EN
    logic [17:0] r_buf_tag_q,   w_buf_tag_d;
    logic [15:0] r_buf_data_q,  w_buf_data_d;
    logic        r_buf_valid_q, w_buf_valid_d;
`endif

    // BIOS decode has priority so a low BIOS_BASE still maps the ROM.
    logic w_is_bios;
    logic w_is_sram;
    assign w_is_bios = (cpu_address >= BIOS_BASE);
    assign w_is_sram = !w_is_bios && !cpu_address[19];

    // Picks the addressed byte lane out of a 16-bit SRAM word.
    function automatic logic [7:0] f_lane(input logic [15:0] word, input logic odd);
        return odd ? word[15:8] : word[7:0];
    endfunction

    // Next-state, datapath and strobe decode; strobes follow the next state so
    // the registered outputs are valid throughout each state's cycle.
    always_comb begin
        w_state_d       = r_state_q;
        w_wait_d        = r_wait_q;
        w_cpu_rdata_d   = r_cpu_rdata_q;
        w_bios_addr_d   = r_bios_addr_q;
        w_sram_addr_d   = r_sram_addr_q;
        w_sram_dq_out_d = r_sram_dq_out_q;
`ifdef MEM_RESPONDER_READ_BUFFER_EN
        w_buf_tag_d     = r_buf_tag_q;
        w_buf_data_d    = r_buf_data_q;
        w_buf_valid_d   = r_buf_valid_q;
`endif

        case (r_state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (w_is_bios) begin
                        w_state_d     = BIOS;
                        w_bios_addr_d = cpu_address[15:0];
                    end else if (w_is_sram) begin
                        w_sram_addr_d = cpu_address[18:1];
                        w_wait_d      = 3'(SRAM_WAIT);
                        if (cpu_we) begin
                            w_state_d       = SRAM_WR;
                            w_sram_dq_out_d = {cpu_wdata, cpu_wdata};
                        end else begin
                            w_state_d = SRAM_RD;
`ifdef MEM_RESPONDER_READ_BUFFER_EN
                            // Buffer hit answers without touching the SRAM
                            if (r_buf_valid_q && (r_buf_tag_q == cpu_address[18:1])) begin
                                w_state_d     = DONE;
                                w_sram_addr_d = r_sram_addr_q;
                                w_cpu_rdata_d = f_lane(r_buf_data_q, cpu_address[0]);
                            end
`endif
                        end
                    end else begin
                        // Open bus: reads float high, writes vanish
                        w_state_d = DONE;
                        if (!cpu_we) begin
                            w_cpu_rdata_d = 8'hFF;
                        end
                    end
                end
            end
            BIOS: begin
                w_state_d = DONE;
                if (!cpu_we) begin
                    w_cpu_rdata_d = bios_data;
                end
            end
            SRAM_RD: begin
                if (r_wait_q == 3'd0) begin
                    w_state_d     = DONE;
                    w_cpu_rdata_d = f_lane(sram_dq_in, cpu_address[0]);
`ifdef MEM_RESPONDER_READ_BUFFER_EN
                    w_buf_tag_d   = r_sram_addr_q;
                    w_buf_data_d  = sram_dq_in;
                    w_buf_valid_d = 1'b1;
`endif
                end else begin
                    w_wait_d = r_wait_q - 3'd1;
                end
            end
            SRAM_WR: begin
                if (r_wait_q == 3'd0) begin
                    w_state_d = DONE;
`ifdef MEM_RESPONDER_READ_BUFFER_EN
                    // Keep the buffered word coherent with the written lane
                    if (r_buf_valid_q && (r_buf_tag_q == r_sram_addr_q)) begin
                        if (cpu_address[0]) begin
                            w_buf_data_d[15:8] = cpu_wdata;
                        end else begin
                            w_buf_data_d[7:0] = cpu_wdata;
                        end
                    end
`endif
                end else begin
                    w_wait_d = r_wait_q - 3'd1;
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        w_cpu_ready_d  = (w_state_d == DONE);
        w_sram_we_n_d  = 1'b1;
        w_sram_oe_n_d  = 1'b1;
        w_sram_ub_n_d  = 1'b1;
        w_sram_lb_n_d  = 1'b1;
        w_sram_dq_oe_d = 1'b0;
        if (w_state_d == SRAM_RD) begin
            w_sram_oe_n_d = 1'b0;
            w_sram_ub_n_d = 1'b0;
            w_sram_lb_n_d = 1'b0;
        end else if (w_state_d == SRAM_WR) begin
            w_sram_we_n_d  = 1'b0;
            w_sram_dq_oe_d = 1'b1;
            w_sram_lb_n_d  = cpu_address[0];
            w_sram_ub_n_d  = ~cpu_address[0];
        end else if ((w_state_d == DONE) && (r_state_q == SRAM_WR)) begin
            // Keep driving data for one cycle after we_n rises (hold time)
            w_sram_dq_oe_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q       <= IDLE;
            r_wait_q        <= 3'd0;
            r_cpu_ready_q   <= 1'b0;
            r_cpu_rdata_q   <= 8'h00;
            r_bios_addr_q   <= 16'h0000;
            r_sram_addr_q   <= 18'h00000;
            r_sram_dq_out_q <= 16'h0000;
            r_sram_dq_oe_q  <= 1'b0;
            r_sram_we_n_q   <= 1'b1;
            r_sram_oe_n_q   <= 1'b1;
            r_sram_ub_n_q   <= 1'b1;
            r_sram_lb_n_q   <= 1'b1;
`ifdef MEM_RESPONDER_READ_BUFFER_EN
            r_buf_tag_q     <= 18'h00000;
            r_buf_data_q    <= 16'h0000;
            r_buf_valid_q   <= 1'b0;
`endif
        end else begin
            r_state_q       <= w_state_d;
            r_wait_q        <= w_wait_d;
            r_cpu_ready_q   <= w_cpu_ready_d;
            r_cpu_rdata_q   <= w_cpu_rdata_d;
            r_bios_addr_q   <= w_bios_addr_d;
            r_sram_addr_q   <= w_sram_addr_d;
            r_sram_dq_out_q <= w_sram_dq_out_d;
            r_sram_dq_oe_q  <= w_sram_dq_oe_d;
            r_sram_we_n_q   <= w_sram_we_n_d;
            r_sram_oe_n_q   <= w_sram_oe_n_d;
            r_sram_ub_n_q   <= w_sram_ub_n_d;
            r_sram_lb_n_q   <= w_sram_lb_n_d;
`ifdef MEM_RESPONDER_READ_BUFFER_EN
            r_buf_tag_q     <= w_buf_tag_d;
            r_buf_data_q    <= w_buf_data_d;
            r_buf_valid_q   <= w_buf_valid_d;
`endif
        end
    end

    assign cpu_ready   = r_cpu_ready_q;
    assign cpu_rdata   = r_cpu_rdata_q;
    assign bios_addr   = r_bios_addr_q;
    assign sram_addr   = r_sram_addr_q;
    assign sram_dq_out = r_sram_dq_out_q;
    assign sram_dq_oe  = r_sram_dq_oe_q;
    assign sram_we_n   = r_sram_we_n_q;
    assign sram_oe_n   = r_sram_oe_n_q;
    assign sram_ub_n   = r_sram_ub_n_q;
    assign sram_lb_n   = r_sram_lb_n_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Directed self-checking bench for mem_responder with a BIOS ROM
//            model, a byte-lane SRAM model and an rdata scoreboard.
// Options  : honours MEM_RESPONDER_READ_BUFFER_EN for hit latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int W = 1;
`ifdef MEM_RESPONDER_READ_BUFFER_EN
    localparam int HIT_LAT = 1;
    localparam int HIT_OE  = 0;
`else
    localparam int HIT_LAT = W + 2;
    localparam int HIT_OE  = W + 1;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [19:0] cpu_address;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic [15:0] bios_addr;
    logic [7:0]  bios_data;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_in;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    mem_responder #(.SRAM_WAIT(W), .BIOS_BASE(20'hF0000)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .bios_addr(bios_addr), .bios_data(bios_data),
        .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    always #5 clock = ~clock;

    // Asynchronous ROM: data for FFF0 is F0 ^ 1A = EA
    assign bios_data = bios_addr[7:0] ^ 8'h1A;

    // SRAM model: asynchronous read, byte-lane write while we_n is low
    logic [15:0] mem [0:4095];
    logic        mem_init;
    assign sram_dq_in = mem[sram_addr[11:0]];
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
            mem[12'h800] <= 16'hC3A5;
        end else if (!sram_we_n) begin
            if (!sram_lb_n) mem[sram_addr[11:0]][7:0]  <= sram_dq_out[7:0];
            if (!sram_ub_n) mem[sram_addr[11:0]][15:8] <= sram_dq_out[15:8];
        end
    end

    // Strobe monitor: free-running counters plus capture of write strobes
    int          n_oe = 0, n_we = 0, n_both = 0;
    logic        cap_ub, cap_lb, cap_dqoe;
    logic [17:0] cap_addr;
    logic [15:0] cap_dq;
    always @(negedge clock) begin
        if (!sram_oe_n) n_oe++;
        if (!sram_oe_n && !sram_we_n) n_both++;
        if (!sram_we_n) begin
            n_we++;
            cap_ub   = sram_ub_n;
            cap_lb   = sram_lb_n;
            cap_addr = sram_addr;
            cap_dq   = sram_dq_out;
            cap_dqoe = sram_dq_oe;
        end
    end

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q [$];
    int         last_oe, last_we, last_both;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CPU access starting in IDLE at a negedge; returns one cycle after DONE
    task automatic access(input string tag, input logic [19:0] a, input logic we,
                          input logic [7:0] wd, input int exp_lat, input logic [7:0] exp_rd);
        int cyc;
        int oe0, we0, both0;
        logic [7:0] e;
        oe0 = n_oe; we0 = n_we; both0 = n_both;
        cpu_address = a; cpu_we = we; cpu_wdata = wd; cpu_req = 1'b1;
        exp_q.push_back(exp_rd);
        @(posedge clock);
        @(negedge clock);
        cpu_req = 1'b0;
        cyc = 1;
        while (!cpu_ready && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        chk({tag, " ready"}, {31'd0, cpu_ready}, 32'd1);
        chk({tag, " latency"}, cyc, exp_lat);
        e = exp_q.pop_front();
        chk({tag, " rdata"}, {24'd0, cpu_rdata}, {24'd0, e});
        @(negedge clock);
        chk({tag, " pulse"}, {31'd0, cpu_ready}, 32'd0);
        last_oe = n_oe - oe0; last_we = n_we - we0; last_both = n_both - both0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rdy_seen;
        reset = 1'b1; mem_init = 1'b1;
        cpu_req = 1'b0; cpu_address = 20'h0; cpu_we = 1'b0; cpu_wdata = 8'h0;
        repeat (3) @(negedge clock);
        // reset values
        chk("rst ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst rdata", {24'd0, cpu_rdata}, 32'h00);
        chk("rst strobes", {28'd0, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, 32'hF);
        chk("rst dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("rst sram_addr", {14'd0, sram_addr}, 32'd0);
        chk("rst bios_addr", {16'd0, bios_addr}, 32'd0);
        reset = 1'b0; mem_init = 1'b0;
        @(negedge clock);

        // BIOS read
        access("bios rd", 20'hFFFF0, 1'b0, 8'h00, 2, 8'hEA);
        chk("bios addr", {16'd0, bios_addr}, 32'hFFF0);
        chk("bios no sram", last_oe + last_we, 0);

        // SRAM write odd byte then read it back
        access("sram wr", 20'h00401, 1'b1, 8'h5A, W + 2, 8'hEA);
        chk("wr we cycles", last_we, W + 1);
        chk("wr addr", {14'd0, cap_addr}, 32'h00200);
        chk("wr lanes ub/lb", {30'd0, cap_ub, cap_lb}, 32'b01);
        chk("wr dq", {16'd0, cap_dq}, 32'h5A5A);
        chk("wr dq_oe", {31'd0, cap_dqoe}, 32'd1);
        chk("idle dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("idle we_n", {31'd0, sram_we_n}, 32'd1);
        access("sram rd hi", 20'h00401, 1'b0, 8'h00, W + 2, 8'h5A);
        chk("rd oe cycles", last_oe, W + 1);
        chk("rd no overlap", last_both, 0);
        access("sram rd lo", 20'h00400, 1'b0, 8'h00, HIT_LAT, 8'h00);
        chk("rd lo oe", last_oe, HIT_OE);

        // Open bus and ignored writes keep rdata
        access("open rd", 20'h90000, 1'b0, 8'h00, 1, 8'hFF);
        chk("open no strobes", last_oe + last_we, 0);
        chk("open bios_addr", {16'd0, bios_addr}, 32'hFFF0);
        access("sram rd 401", 20'h00401, 1'b0, 8'h00, HIT_LAT, 8'h5A);
        access("open wr", 20'h90000, 1'b1, 8'h33, 1, 8'h5A);
        chk("open wr strobes", last_oe + last_we, 0);
        access("bios wr", 20'hFFFF8, 1'b1, 8'h99, 2, 8'h5A);
        chk("bios wr strobes", last_oe + last_we, 0);

        // Read buffer behaviour (full SRAM path when disabled)
        access("buf rd 1000", 20'h01000, 1'b0, 8'h00, W + 2, 8'hA5);
        chk("buf fill oe", last_oe, W + 1);
        access("buf rd 1001", 20'h01001, 1'b0, 8'h00, HIT_LAT, 8'hC3);
        chk("buf hit oe", last_oe, HIT_OE);
        access("buf wr 1001", 20'h01001, 1'b1, 8'h77, W + 2, 8'hC3);
        access("buf rd after wr", 20'h01001, 1'b0, 8'h00, HIT_LAT, 8'h77);
        chk("buf rd after wr oe", last_oe, HIT_OE);

        // Reset during the second SRAM_WR cycle
        cpu_address = 20'h00600; cpu_we = 1'b1; cpu_wdata = 8'h11; cpu_req = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cpu_req = 1'b0;
        @(negedge clock);
        chk("mid wr we_n", {31'd0, sram_we_n}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("mid rst we_n", {31'd0, sram_we_n}, 32'd1);
        chk("mid rst dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("mid rst rdata", {24'd0, cpu_rdata}, 32'h00);
        reset = 1'b0;
        rdy_seen = (cpu_ready === 1'b1) ? 1 : 0;
        repeat (5) begin
            @(negedge clock);
            if (cpu_ready !== 1'b0) rdy_seen++;
        end
        chk("mid rst no ready", rdy_seen, 0);
        access("post rst rd", 20'h01001, 1'b0, 8'h00, W + 2, 8'h77);
        chk("post rst oe", last_oe, W + 1);
        chk("no overlap total", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter SRAM_WAIT, default 1; extra wait cycles per SRAM access (range 0..7).
REQ-002 SHALL have parameter BIOS_BASE, default 20'hF0000; first byte of the internal BIOS region, which runs to 20'hFFFFF.
REQ-003 SHALL have a single clock port `clock` (1 bit, input); all logic on its rising edge.
REQ-004 SHALL have port `reset` (1 bit, input); reset is synchronous and active-high.
REQ-005 SHALL have CPU-side ports:
- cpu_req (1, in): request strobe.
- cpu_address (20, in): byte address.
- cpu_we (1, in): 1 = write.
- cpu_wdata (8, in): write byte.
- cpu_rdata (8, out): read byte.
- cpu_ready (1, out): one-cycle completion pulse.
REQ-006 SHALL have BIOS-side ports:
- bios_addr (16, out): BIOS byte address.
- bios_data (8, in): BIOS read data, valid 1 cycle after bios_addr.
REQ-007 SHALL have SRAM-side ports:
- sram_addr (18, out): SRAM word address.
- sram_dq_in (16, in): SRAM read data.
- sram_dq_out (16, out): SRAM write data.
- sram_dq_oe (1, out): 1 = drive sram_dq_out onto the bus.
- sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n (1 each, out): active-low SRAM strobes.

Function
REQ-008 SHALL decode each request by address into one of three regions:
- BIOS: address >= BIOS_BASE.
- SRAM: address < 20'h80000.
- Open bus: every other address.
REQ-009 SHALL use FSM states IDLE, BIOS, SRAM_RD, SRAM_WR, DONE, and SHALL sample cpu_req only in IDLE.
REQ-010 The CPU SHALL hold cpu_address, cpu_we and cpu_wdata stable from cpu_req until cpu_ready; behaviour on violation is undefined.
REQ-011 BIOS read: IDLE -> BIOS (bios_addr = address[15:0]) -> DONE.
- cpu_rdata = bios_data.
- cpu_ready is high in DONE, two cycles after the request is sampled.
REQ-012 BIOS write SHALL be ignored, with cpu_ready asserted the same way as a BIOS read.
REQ-013 Open-bus access: IDLE -> DONE.
- A read returns cpu_rdata = 8'hFF.
- A write is discarded.
REQ-014 SRAM read: SRAM_RD is held for SRAM_WAIT+1 cycles, then DONE.
- Strobes: sram_oe_n = 0, sram_ub_n = sram_lb_n = 0, sram_addr = address[18:1].
- The 16-bit word is latched on the last SRAM_RD cycle.
- cpu_rdata = address[0] ? word[15:8] : word[7:0].
REQ-015 SRAM write: SRAM_WR is held for SRAM_WAIT+1 cycles, then DONE.
- Strobes: sram_we_n = 0, sram_dq_oe = 1, sram_dq_out = {wdata, wdata}.
- Lane select: sram_lb_n = address[0]; sram_ub_n = ~address[0].
REQ-016 sram_we_n SHALL deassert in DONE while sram_addr and sram_dq_out are held for one further cycle (hold time).
REQ-017 cpu_ready SHALL be a single-cycle pulse in DONE; DONE -> IDLE unconditionally.
- A new request can be sampled on the cycle after DONE at the earliest.
REQ-018 cpu_rdata SHALL hold its last read value through writes and idle cycles.
REQ-019 Outside active states, all SRAM strobes SHALL be high and sram_dq_oe SHALL be 0.
- sram_we_n and sram_oe_n SHALL never be low in the same cycle.

Reset
REQ-020 When reset = 1, the block SHALL go to IDLE on the next clock edge, including mid-access.
REQ-021 Reset values: cpu_ready = 0, cpu_rdata = 8'h00, sram_we_n = sram_oe_n = sram_ub_n = sram_lb_n = 1, sram_dq_oe = 0, sram_addr = 0, bios_addr = 0.
REQ-022 Reset SHALL also clear the wait counter and invalidate the read buffer.
- A request that reset interrupts SHALL never produce cpu_ready.

Configuration
REQ-023 With macro MEM_RESPONDER_READ_BUFFER_EN defined, SHALL keep a one-word read buffer: 18-bit tag, 16-bit data, valid bit.
- Fill: every completed SRAM read loads the buffer.
- Hit: an SRAM read whose word address equals the valid tag goes IDLE -> DONE with no SRAM strobes.
- Write to the buffered word: updates the buffered byte lane in the same DONE cycle.
REQ-024 Without the macro, every SRAM read SHALL take the full SRAM_RD path, and no buffer storage SHALL be synthesised.

Verification
REQ-025 BIOS read 20'hFFFF0 with bios_data = 8'hEA -> bios_addr = 16'hFFF0; cpu_ready 2 cycles later; cpu_rdata = 8'hEA.
REQ-026 SRAM write 20'h00401 = 8'h5A, then read the same address, SRAM_WAIT = 1 -> write: sram_addr = 18'h00200, ub_n = 0, lb_n = 1, we_n low 2 cycles; read: cpu_rdata = 8'h5A, cpu_ready 3 cycles after sampling.
REQ-027 Read 20'h90000 -> cpu_rdata = 8'hFF, cpu_ready next cycle, no SRAM/BIOS strobes; a write there changes nothing.
REQ-028 With the macro defined: read 20'h01000, then 20'h01001 -> second read hits with no sram_oe_n pulse and returns the high byte.
- Then write 20'h01001 = 8'h77 and read it -> hit returns 8'h77.
REQ-029 Assert reset during the second SRAM_WR cycle -> no cpu_ready; next cycle sram_we_n = 1, sram_dq_oe = 0, state IDLE; a following read completes normally.
